// File: rtl/axi4lite_pkg.sv
// Shared types and address decoding for the AXI4-Lite register file slave.
package axi4lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_RESP = 1'b1
   } wr_state_t;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_DATA = 1'b1
   } rd_state_t;

   typedef struct packed {
      logic       err;
      logic [7:0] idx;
   } dec_t;

   // Word index sits above the byte-lane bits; any set bit above the index field is an error.
   function automatic dec_t addr_decode(input logic [63:0] addr, input int ofs,
                                        input int idxw, input int num_regs);
      dec_t        d;
      logic [63:0] sh;
      sh    = addr >> ofs;
      d.idx = sh[7:0] & 8'((16'd1 << idxw) - 16'd1);
      d.err = (int'(d.idx) >= num_regs) || ((sh >> idxw) != 64'd0);
      return d;
   endfunction

endpackage

// File: rtl/axi4lite_regfile_core.sv
// Register storage with byte-strobe writes, per-register write pulses and a read mux.
module axi4lite_regfile_core
   import axi4lite_pkg::*;
#(
   parameter int DW       = 32,
   parameter int NUM_REGS = 16,
   parameter int IDXW     = 4
) (
   input  logic                   A_CLK,
   input  logic                   A_RST,
   input  logic                   wr_en,
   input  logic [IDXW-1:0]        wr_idx,
   input  logic [DW-1:0]          wr_data,
   input  logic [DW/8-1:0]        wr_strb,
   input  logic [IDXW-1:0]        rd_idx,
   output logic [DW-1:0]          rd_data,
   output logic [NUM_REGS*DW-1:0] reg_q,
   output logic [NUM_REGS-1:0]    wr_pulse
);

   localparam int SW = DW / 8;

   logic [DW-1:0] q_arr [NUM_REGS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic [DW-1:0] q_reg;
         logic          p_reg;
         logic          sel;

         assign sel = wr_en && (int'(wr_idx) == gi);

         always_ff @(posedge A_CLK or posedge A_RST) begin
            if (A_RST) begin
               q_reg <= '0;
               p_reg <= 1'b0;
            end else begin
               p_reg <= sel;
               if (sel) begin
                  for (int b = 0; b < SW; b++) begin
                     if (wr_strb[b]) q_reg[b*8 +: 8] <= wr_data[b*8 +: 8];
                  end
               end
            end
         end

         assign q_arr[gi]              = q_reg;
         assign reg_q[gi*DW +: DW]     = q_reg;
         assign wr_pulse[gi]           = p_reg;
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      if (int'(rd_idx) < NUM_REGS) rd_data = q_arr[rd_idx];
   end

endmodule

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite slave front end: independent write (AW/W in any order) and read paths over the register core.
module axi4lite_regfile_slave
   import axi4lite_pkg::*;
#(
   parameter int                  AXI_ADDR_WIDTH = 32,
   parameter int                  AXI_DATA_WIDTH = 32,
   parameter int                  NUM_REGS       = 16,
   parameter logic [NUM_REGS-1:0] RO_MASK        = '0
) (
   input  logic                               A_CLK,
   input  logic                               A_RST,
   input  logic                               AW_VALID,
   output logic                               AW_READY,
   input  logic [AXI_ADDR_WIDTH-1:0]          AW_ADDR,
   input  logic                               W_VALID,
   output logic                               W_READY,
   input  logic [AXI_DATA_WIDTH-1:0]          W_DATA,
   input  logic [AXI_DATA_WIDTH/8-1:0]        W_STRB,
   output logic                               B_VALID,
   input  logic                               B_READY,
   output logic [1:0]                         B_RESP,
   input  logic                               AR_VALID,
   output logic                               AR_READY,
   input  logic [AXI_ADDR_WIDTH-1:0]          AR_ADDR,
   output logic                               R_VALID,
   input  logic                               R_READY,
   output logic [AXI_DATA_WIDTH-1:0]          R_DATA,
   output logic [1:0]                         R_RESP,
   output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] REG_Q,
   output logic [NUM_REGS-1:0]                WR_PULSE,
   input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0] RO_D
);

   localparam int DW   = AXI_DATA_WIDTH;
   localparam int SW   = DW / 8;
   localparam int OFS  = $clog2(SW);
   localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic                      rdy_en_reg;
   wr_state_t                 wr_state_reg;
   rd_state_t                 rd_state_reg;
   logic                      aw_held_reg, w_held_reg;
   logic [AXI_ADDR_WIDTH-1:0] aw_addr_reg;
   logic [DW-1:0]             w_data_reg, r_data_reg, r_data_next, core_rd_data;
   logic [SW-1:0]             w_strb_reg;
   resp_t                     b_resp_reg, r_resp_reg, r_resp_next;

   logic                      aw_hs, w_hs, ar_hs, commit, wr_reject, wr_en;
   logic [AXI_ADDR_WIDTH-1:0] wr_addr;
   logic [DW-1:0]             wr_data;
   logic [SW-1:0]             wr_strb;
   dec_t                      wr_dec, rd_dec;
   logic [IDXW-1:0]           wr_idx, rd_idx;

   // Readies stay low during reset and rise one cycle after release.
   assign AW_READY = rdy_en_reg && (wr_state_reg == WR_IDLE) && !aw_held_reg;
   assign W_READY  = rdy_en_reg && (wr_state_reg == WR_IDLE) && !w_held_reg;
   assign AR_READY = rdy_en_reg && (rd_state_reg == RD_IDLE);
   assign B_VALID  = (wr_state_reg == WR_RESP);
   assign B_RESP   = b_resp_reg;
   assign R_VALID  = (rd_state_reg == RD_DATA);
   assign R_DATA   = r_data_reg;
   assign R_RESP   = r_resp_reg;

   assign aw_hs  = AW_VALID && AW_READY;
   assign w_hs   = W_VALID && W_READY;
   assign ar_hs  = AR_VALID && AR_READY;
   assign commit = (wr_state_reg == WR_IDLE) && (aw_held_reg || aw_hs) && (w_held_reg || w_hs);

   assign wr_addr = aw_hs ? AW_ADDR : aw_addr_reg;
   assign wr_data = w_hs ? W_DATA : w_data_reg;
   assign wr_strb = w_hs ? W_STRB : w_strb_reg;

   assign wr_dec    = addr_decode(64'(wr_addr), OFS, IDXW, NUM_REGS);
   assign wr_idx    = wr_dec.idx[IDXW-1:0];
   assign wr_reject = wr_dec.err || RO_MASK[wr_idx];
   assign wr_en     = commit && !wr_reject;

   assign rd_dec = addr_decode(64'(AR_ADDR), OFS, IDXW, NUM_REGS);
   assign rd_idx = rd_dec.idx[IDXW-1:0];

   always_comb begin
      r_data_next = core_rd_data;
      r_resp_next = OKAY;
      if (rd_dec.err) begin
         r_data_next = '0;
         r_resp_next = SLVERR;
      end else if (RO_MASK[rd_idx]) begin
         r_data_next = RO_D[rd_idx*DW +: DW];
      end
   end

   always_ff @(posedge A_CLK or posedge A_RST) begin
      if (A_RST) rdy_en_reg <= 1'b0;
      else       rdy_en_reg <= 1'b1;
   end

   always_ff @(posedge A_CLK or posedge A_RST) begin
      if (A_RST) begin
         wr_state_reg <= WR_IDLE;
         aw_held_reg  <= 1'b0;
         w_held_reg   <= 1'b0;
         aw_addr_reg  <= '0;
         w_data_reg   <= '0;
         w_strb_reg   <= '0;
         b_resp_reg   <= OKAY;
      end else begin
         case (wr_state_reg)
            WR_IDLE: begin
               if (commit) begin
                  aw_held_reg  <= 1'b0;
                  w_held_reg   <= 1'b0;
                  b_resp_reg   <= wr_reject ? SLVERR : OKAY;
                  wr_state_reg <= WR_RESP;
               end else begin
                  if (aw_hs) begin
                     aw_held_reg <= 1'b1;
                     aw_addr_reg <= AW_ADDR;
                  end
                  if (w_hs) begin
                     w_held_reg <= 1'b1;
                     w_data_reg <= W_DATA;
                     w_strb_reg <= W_STRB;
                  end
               end
            end
            default: if (B_READY) wr_state_reg <= WR_IDLE;
         endcase
      end
   end

   always_ff @(posedge A_CLK or posedge A_RST) begin
      if (A_RST) begin
         rd_state_reg <= RD_IDLE;
         r_data_reg   <= '0;
         r_resp_reg   <= OKAY;
      end else begin
         case (rd_state_reg)
            RD_IDLE: begin
               if (ar_hs) begin
                  r_data_reg   <= r_data_next;
                  r_resp_reg   <= r_resp_next;
                  rd_state_reg <= RD_DATA;
               end
            end
            default: if (R_READY) rd_state_reg <= RD_IDLE;
         endcase
      end
   end

   axi4lite_regfile_core #(
      .DW       (DW),
      .NUM_REGS (NUM_REGS),
      .IDXW     (IDXW)
   ) u_core (
      .A_CLK    (A_CLK),
      .A_RST    (A_RST),
      .wr_en    (wr_en),
      .wr_idx   (wr_idx),
      .wr_data  (wr_data),
      .wr_strb  (wr_strb),
      .rd_idx   (rd_idx),
      .rd_data  (core_rd_data),
      .reg_q    (REG_Q),
      .wr_pulse (WR_PULSE)
   );

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Directed bench for axi4lite_regfile_slave (DW=32, 16 registers, register 15 read-only).
module tb_axi4lite_regfile_slave;

   logic          A_CLK = 1'b0;
   logic          A_RST;
   logic          AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
   logic          AR_VALID, AR_READY, R_VALID, R_READY;
   logic [31:0]   AW_ADDR, AR_ADDR, W_DATA, R_DATA;
   logic [3:0]    W_STRB;
   logic [1:0]    B_RESP, R_RESP;
   logic [511:0]  REG_Q, RO_D;
   logic [15:0]   WR_PULSE;

   int checks = 0;
   int errors = 0;

   always #5 A_CLK = ~A_CLK;

   axi4lite_regfile_slave #(
      .AXI_ADDR_WIDTH (32),
      .AXI_DATA_WIDTH (32),
      .NUM_REGS       (16),
      .RO_MASK        (16'h8000)
   ) dut (
      .A_CLK    (A_CLK),
      .A_RST    (A_RST),
      .AW_VALID (AW_VALID),
      .AW_READY (AW_READY),
      .AW_ADDR  (AW_ADDR),
      .W_VALID  (W_VALID),
      .W_READY  (W_READY),
      .W_DATA   (W_DATA),
      .W_STRB   (W_STRB),
      .B_VALID  (B_VALID),
      .B_READY  (B_READY),
      .B_RESP   (B_RESP),
      .AR_VALID (AR_VALID),
      .AR_READY (AR_READY),
      .AR_ADDR  (AR_ADDR),
      .R_VALID  (R_VALID),
      .R_READY  (R_READY),
      .R_DATA   (R_DATA),
      .R_RESP   (R_RESP),
      .REG_Q    (REG_Q),
      .WR_PULSE (WR_PULSE),
      .RO_D     (RO_D)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rq(input int i);
      return REG_Q[i*32 +: 32];
   endfunction

   task automatic tick();
      @(posedge A_CLK);
      #1;
   endtask

   task automatic write_same(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      AW_VALID = 1'b1; AW_ADDR = a;
      W_VALID  = 1'b1; W_DATA  = d; W_STRB = s;
      tick();
      AW_VALID = 1'b0; W_VALID = 1'b0;
   endtask

   task automatic b_accept();
      B_READY = 1'b1;
      tick();
      B_READY = 1'b0;
      chk("b_valid_clear", 64'(B_VALID), 64'(0));
   endtask

   task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
      AR_VALID = 1'b1; AR_ADDR = a;
      tick();
      AR_VALID = 1'b0;
      chk({tag, "_rvalid"}, 64'(R_VALID), 64'(1));
      chk({tag, "_rdata"},  64'(R_DATA),  64'(d));
      chk({tag, "_rresp"},  64'(R_RESP),  64'(r));
      R_READY = 1'b1;
      tick();
      R_READY = 1'b0;
      chk({tag, "_rvalid_clear"}, 64'(R_VALID), 64'(0));
   endtask

   initial begin
      A_RST = 1'b1;
      AW_VALID = 1'b0; AW_ADDR = '0; W_VALID = 1'b0; W_DATA = '0; W_STRB = '0;
      B_READY = 1'b0; AR_VALID = 1'b0; AR_ADDR = '0; R_READY = 1'b0;
      RO_D = '0;
      RO_D[15*32 +: 32] = 32'h5A5A0001;

      tick();
      chk("rst_aw_ready", 64'(AW_READY), 64'(0));
      chk("rst_ar_ready", 64'(AR_READY), 64'(0));
      chk("rst_b_valid",  64'(B_VALID),  64'(0));
      chk("rst_reg_q",    64'(REG_Q == '0), 64'(1));
      A_RST = 1'b0;
      #1;
      chk("post_rst_aw_ready_low", 64'(AW_READY), 64'(0));
      tick();
      chk("post_rst_aw_ready", 64'(AW_READY), 64'(1));
      chk("post_rst_w_ready",  64'(W_READY),  64'(1));
      chk("post_rst_ar_ready", 64'(AR_READY), 64'(1));

      // 1: simultaneous AW/W to register 2
      write_same(32'h08, 32'hDEADBEEF, 4'hF);
      $display("write 0x08 data DEADBEEF strb F");
      chk("t1_b_valid", 64'(B_VALID), 64'(1));
      chk("t1_b_resp",  64'(B_RESP),  64'(2'b00));
      chk("t1_reg2",    64'(rq(2)),   64'(32'hDEADBEEF));
      chk("t1_pulse",   64'(WR_PULSE), 64'(16'h0004));
      chk("t1_aw_ready_resp", 64'(AW_READY), 64'(0));
      tick();
      chk("t1_pulse_once", 64'(WR_PULSE), 64'(16'h0000));
      chk("t1_b_hold",     64'(B_VALID),  64'(1));
      b_accept();
      read_chk("t1_rd", 32'h08, 32'hDEADBEEF, 2'b00);
      $display("read 0x08");

      // 2: W first, AW three cycles later, partial strobe
      write_same(32'h0C, 32'hAAAAAAAA, 4'hF);
      b_accept();
      W_VALID = 1'b1; W_DATA = 32'h11223344; W_STRB = 4'b0101;
      tick();
      W_VALID = 1'b0;
      chk("t2_w_ready_held", 64'(W_READY), 64'(0));
      chk("t2_no_b",         64'(B_VALID), 64'(0));
      tick();
      tick();
      chk("t2_no_b_later",   64'(B_VALID), 64'(0));
      chk("t2_reg3_old",     64'(rq(3)),   64'(32'hAAAAAAAA));
      AW_VALID = 1'b1; AW_ADDR = 32'h0C;
      tick();
      AW_VALID = 1'b0;
      $display("write 0x0C data 11223344 strb 5 (W before AW)");
      chk("t2_b_valid", 64'(B_VALID), 64'(1));
      chk("t2_b_resp",  64'(B_RESP),  64'(2'b00));
      chk("t2_reg3",    64'(rq(3)),   64'(32'hAA22AA44));
      chk("t2_pulse",   64'(WR_PULSE), 64'(16'h0008));
      b_accept();

      // 3: out-of-range address
      read_chk("t3_rd", 32'h40, 32'h0, 2'b10);
      $display("read 0x40");
      write_same(32'h40, 32'hFFFFFFFF, 4'hF);
      $display("write 0x40");
      chk("t3_b_resp", 64'(B_RESP),  64'(2'b10));
      chk("t3_pulse",  64'(WR_PULSE), 64'(16'h0000));
      chk("t3_reg0",   64'(rq(0)),   64'(32'h0));
      chk("t3_reg2",   64'(rq(2)),   64'(32'hDEADBEEF));
      b_accept();

      // 4: read-only register 15
      write_same(32'h3C, 32'h12345678, 4'hF);
      $display("write 0x3C (read-only)");
      chk("t4_b_resp", 64'(B_RESP),  64'(2'b10));
      chk("t4_pulse",  64'(WR_PULSE), 64'(16'h0000));
      chk("t4_reg15",  64'(rq(15)),  64'(32'h0));
      b_accept();
      read_chk("t4_rd", 32'h3C, 32'h5A5A0001, 2'b00);
      $display("read 0x3C");

      // zero strobe: OKAY, pulse, no data change
      write_same(32'h10, 32'hFFFFFFFF, 4'h0);
      $display("write 0x10 strb 0");
      chk("t4z_b_resp", 64'(B_RESP),  64'(2'b00));
      chk("t4z_pulse",  64'(WR_PULSE), 64'(16'h0010));
      chk("t4z_reg4",   64'(rq(4)),   64'(32'h0));
      b_accept();

      // 5: concurrent write+read of register 2 on the same edge, both with stalled ready
      AW_VALID = 1'b1; AW_ADDR = 32'h08; W_VALID = 1'b1; W_DATA = 32'h0BADF00D; W_STRB = 4'hF;
      AR_VALID = 1'b1; AR_ADDR = 32'h08;
      tick();
      AW_VALID = 1'b0; W_VALID = 1'b0; AR_VALID = 1'b0;
      $display("concurrent write/read 0x08");
      chk("t5_reg2_new", 64'(rq(2)), 64'(32'h0BADF00D));
      for (int i = 0; i < 6; i++) begin
         chk("t5_b_valid",  64'(B_VALID),  64'(1));
         chk("t5_b_resp",   64'(B_RESP),   64'(2'b00));
         chk("t5_aw_ready", 64'(AW_READY), 64'(0));
         if (i < 5) begin
            chk("t5_r_valid",  64'(R_VALID),  64'(1));
            chk("t5_r_data",   64'(R_DATA),   64'(32'hDEADBEEF));
            chk("t5_r_resp",   64'(R_RESP),   64'(2'b00));
            chk("t5_ar_ready", 64'(AR_READY), 64'(0));
         end else begin
            chk("t5_r_done",   64'(R_VALID),  64'(0));
            chk("t5_ar_back",  64'(AR_READY), 64'(1));
         end
         R_READY = (i == 4);
         B_READY = (i == 5);
         tick();
      end
      R_READY = 1'b0; B_READY = 1'b0;
      chk("t5_b_done",   64'(B_VALID),  64'(0));
      chk("t5_aw_back",  64'(AW_READY), 64'(1));

      // 6: reset after AW, before W
      AW_VALID = 1'b1; AW_ADDR = 32'h14;
      tick();
      AW_VALID = 1'b0;
      #2;
      A_RST = 1'b1;
      #1;
      $display("reset asserted with AW held");
      chk("t6_aw_ready", 64'(AW_READY), 64'(0));
      chk("t6_w_ready",  64'(W_READY),  64'(0));
      chk("t6_ar_ready", 64'(AR_READY), 64'(0));
      chk("t6_reg_q",    64'(REG_Q == '0), 64'(1));
      chk("t6_pulse",    64'(WR_PULSE), 64'(0));
      chk("t6_r_data",   64'(R_DATA),   64'(0));
      tick();
      A_RST = 1'b0;
      tick();
      W_VALID = 1'b1; W_DATA = 32'hCAFE0005; W_STRB = 4'hF;
      tick();
      W_VALID = 1'b0;
      chk("t6_no_b", 64'(B_VALID), 64'(0));
      tick();
      tick();
      chk("t6_no_b_later", 64'(B_VALID), 64'(0));
      chk("t6_reg5_old",   64'(rq(5)),   64'(32'h0));
      AW_VALID = 1'b1; AW_ADDR = 32'h14;
      tick();
      AW_VALID = 1'b0;
      $display("write 0x14 after reset (fresh AW)");
      chk("t6_b_valid", 64'(B_VALID), 64'(1));
      chk("t6_reg5",    64'(rq(5)),   64'(32'hCAFE0005));
      b_accept();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
